rx_link_ctrl: RTL

- Sequencing controller for the 16-lane RX datapath (PIPE RX data stage, per-lane descramblers, LMC).
- Qualifies electrical-idle exit and checks lane lock on the active lanes, then enables the descramblers.
- Handles rate changes using the PhyStatus handshake.
- Drives the shared GEN, LANESNUMBER and turnOff controls, plus a flush pulse to the datapath.

---
 rtl/rx_link_ctrl.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/rx_link_ctrl.sv
// rx_link_ctrl
// Sequencing controller for the 16-lane RX datapath (PIPE RX data stage,
// per-lane descramblers, LMC). It qualifies electrical-idle exit, waits for
// lock on every active lane, then releases the descramblers. Rate changes
// are run through the PhyStatus handshake before lock is re-acquired.
//
// Ports
//   clk, reset          clock, asynchronous active-low reset
//   cfgLanes            requested lane count, sampled only in IDLE
//   cfgScrambleDisable  keep descramblers bypassed while ACTIVE
//   rateChangeReq       single-cycle rate change request, with newGEN
//   PhyStatus           per-lane PHY status pulse
//   RxValid, RxElectricalIdle, RxStartBlock, RxSyncHeader, RxData, RxDataK
//                       per-lane PIPE receive signals
//   GEN, LANESNUMBER    applied rate and lane count
//   turnOff             descrambler bypass
//   pathFlush           one-cycle datapath flush
//   laneActive          mask of active lanes
//   linkUp              high only in ACTIVE
//   rateChangeDone, alignTimeout, phyTimeout  one-cycle status pulses
//   state               IDLE=0, ALIGN=1, ACTIVE=2, RATE_CHG=3
module rx_link_ctrl #(
  parameter int IDLE_DEBOUNCE = 4,
  parameter int ALIGN_TIMEOUT = 1024,
  parameter int PHY_TIMEOUT   = 256
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [4:0]   cfgLanes,
  input  logic         cfgScrambleDisable,
  input  logic         rateChangeReq,
  input  logic [2:0]   newGEN,
  input  logic [15:0]  PhyStatus,
  input  logic [15:0]  RxValid,
  input  logic [15:0]  RxElectricalIdle,
  input  logic [15:0]  RxStartBlock,
  input  logic [31:0]  RxSyncHeader,
  input  logic [511:0] RxData,
  input  logic [63:0]  RxDataK,
  output logic [2:0]   GEN,
  output logic [4:0]   LANESNUMBER,
  output logic         turnOff,
  output logic         pathFlush,
  output logic [15:0]  laneActive,
  output logic         linkUp,
  output logic         rateChangeDone,
  output logic         alignTimeout,
  output logic         phyTimeout,
  output logic [2:0]   state
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] ALIGN    = 3'd1;
  localparam logic [2:0] ACTIVE   = 3'd2;
  localparam logic [2:0] RATE_CHG = 3'd3;

  localparam int IW   = $clog2(IDLE_DEBOUNCE + 1);
  localparam int TMAX = (ALIGN_TIMEOUT > PHY_TIMEOUT) ? ALIGN_TIMEOUT : PHY_TIMEOUT;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [IW-1:0] IDLE_LAST  = IW'(IDLE_DEBOUNCE - 1);
  localparam logic [TW-1:0] ALIGN_LAST = TW'(ALIGN_TIMEOUT - 1);
  localparam logic [TW-1:0] PHY_LAST   = TW'(PHY_TIMEOUT - 1);

  logic [4:0]    cfgCount;
  logic [16:0]   cfgMaskWide;
  logic [15:0]   cfgMask;
  logic [15:0]   lockEvents;
  logic [15:0]   lockMask;
  logic [15:0]   lockNext;
  logic [15:0]   phyMask;
  logic [15:0]   phyNext;
  logic [2:0]    genPending;
  logic [IW-1:0] idleCnt;
  logic [TW-1:0] timer;
  logic          cfgClean;
  logic          activeIdle;
  logic          idleExit;
  logic          rateReqOk;
  logic          unusedBits;

  // Only byte 0 / K bit 0 of each lane matter for COM detection.
  assign unusedBits = ^{cfgMaskWide[16], RxData, RxDataK};

  // Lane count clamp: 0 means one lane, anything above 16 means all 16.
  assign cfgCount = (cfgLanes == 5'd0)  ? 5'd1  :
                    (cfgLanes > 5'd16)  ? 5'd16 : cfgLanes;

  // 17-bit shift so that a count of 16 yields a full 16'hFFFF mask.
  assign cfgMaskWide = (17'd1 << cfgCount) - 17'd1;
  assign cfgMask     = cfgMaskWide[15:0];

  // Lock detection depends on the encoding in use for the applied rate:
  // COM symbol for 8b/10b, a valid sync header on a block start otherwise.
  always_comb begin
    lockEvents = '0;
    for (int i = 0; i < 16; i++) begin
      if (GEN <= 3'd2) begin
        lockEvents[i] = RxValid[i] & RxDataK[4*i] & (RxData[32*i +: 8] == 8'hBC);
      end else begin
        lockEvents[i] = RxValid[i] & RxStartBlock[i] &
                        ((RxSyncHeader[2*i +: 2] == 2'b01) ||
                         (RxSyncHeader[2*i +: 2] == 2'b10));
      end
    end
  end

  assign lockNext   = lockMask | (lockEvents & laneActive);
  assign phyNext    = phyMask  | (PhyStatus  & laneActive);
  assign cfgClean   = ((RxElectricalIdle & cfgMask) == 16'h0000);
  assign activeIdle = |(RxElectricalIdle & laneActive);
  assign idleExit   = activeIdle && (idleCnt == IDLE_LAST);
  assign rateReqOk  = rateChangeReq && (newGEN >= 3'd1) && (newGEN <= 3'd5) &&
                      (newGEN != GEN);

  // Single state/control register block. Pulse outputs default low every
  // cycle so each one lasts exactly one cycle after the transition sets it.
  // idleCnt serves the IDLE exit debounce and the ACTIVE idle detector;
  // timer serves the ALIGN and RATE_CHG timeouts. Both are cleared on entry
  // to the state that uses them.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      GEN            <= 3'd1;
      LANESNUMBER    <= 5'd16;
      laneActive     <= 16'hFFFF;
      turnOff        <= 1'b1;
      pathFlush      <= 1'b0;
      linkUp         <= 1'b0;
      rateChangeDone <= 1'b0;
      alignTimeout   <= 1'b0;
      phyTimeout     <= 1'b0;
      lockMask       <= '0;
      phyMask        <= '0;
      genPending     <= '0;
      idleCnt        <= '0;
      timer          <= '0;
    end else begin
      pathFlush      <= 1'b0;
      rateChangeDone <= 1'b0;
      alignTimeout   <= 1'b0;
      phyTimeout     <= 1'b0;

      case (state)
        IDLE: begin
          linkUp  <= 1'b0;
          turnOff <= 1'b1;
          if (cfgClean) begin
            if (idleCnt == IDLE_LAST) begin
              LANESNUMBER <= cfgCount;
              laneActive  <= cfgMask;
              pathFlush   <= 1'b1;
              lockMask    <= '0;
              timer       <= '0;
              idleCnt     <= '0;
              state       <= ALIGN;
            end else begin
              idleCnt <= idleCnt + IW'(1);
            end
          end else begin
            idleCnt <= '0;
          end
        end

        ALIGN: begin
          lockMask <= lockNext;
          // Full lock is tested first so it wins over a coincident timeout.
          if (lockNext == laneActive) begin
            linkUp  <= 1'b1;
            turnOff <= cfgScrambleDisable;
            idleCnt <= '0;
            state   <= ACTIVE;
          end else if (timer == ALIGN_LAST) begin
            alignTimeout <= 1'b1;
            idleCnt      <= '0;
            state        <= IDLE;
          end else if (timer != '1) begin
            timer <= timer + TW'(1);
          end
        end

        ACTIVE: begin
          // Losing the link takes priority over a rate change request.
          if (idleExit) begin
            pathFlush <= 1'b1;
            linkUp    <= 1'b0;
            turnOff   <= 1'b1;
            idleCnt   <= '0;
            state     <= IDLE;
          end else if (rateReqOk) begin
            genPending <= newGEN;
            pathFlush  <= 1'b1;
            turnOff    <= 1'b1;
            linkUp     <= 1'b0;
            phyMask    <= '0;
            timer      <= '0;
            idleCnt    <= '0;
            state      <= RATE_CHG;
          end else if (activeIdle) begin
            if (idleCnt != IDLE_LAST) begin
              idleCnt <= idleCnt + IW'(1);
            end
          end else begin
            idleCnt <= '0;
          end
        end

        RATE_CHG: begin
          phyMask <= phyNext;
          // Completion is tested first so it wins over a coincident timeout.
          if (phyNext == laneActive) begin
            GEN            <= genPending;
            rateChangeDone <= 1'b1;
            lockMask       <= '0;
            timer          <= '0;
            state          <= ALIGN;
          end else if (timer == PHY_LAST) begin
            phyTimeout <= 1'b1;
            idleCnt    <= '0;
            state      <= IDLE;
          end else if (timer != '1) begin
            timer <= timer + TW'(1);
          end
        end

        default: begin
          linkUp  <= 1'b0;
          turnOff <= 1'b1;
          idleCnt <= '0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule
